firstmatch_monitor: RTL and testbench
=====================================

Name: firstmatch_monitor

Overview:
- Hand-written RTL checker for the property `first_match(A ##1 B[*] ##1 C) |=> D`.
- Sits directly downstream of the trace sequencer and consumes its A/B/C/D outputs.
- Reports per-cycle match and fail pulses, sticky and counted results, and the cycle of the first failure.
- Serves as the synthesizable reference against which the Verific SVA results are cross-checked in the same formal benches.

Parameters:
- FIRST_MATCH, 1, 1 = an attempt retires at its first C; 0 = an attempt stays live through its B-run and matches at every C.
- CNT_W, 8, width of match_count and fail_count (saturating).
- TIME_W, 5, width of the cycle counter and first_fail_cycle (saturating).

Ports:
- clock  in  1  sole clock, posedge.
- resetn  in  1  synchronous, active-low reset.
- A  in  1  sequence start.
- B  in  1  repetition term.
- C  in  1  sequence end.
- D  in  1  consequent, checked the cycle after a match.
- abort  in  1  synchronous; kills in-flight attempts and the pending D-check; counters are kept.
- match  out  1  high in cycle n+1 when at least one attempt matched in cycle n.
- fail  out  1  high in cycle n+2 when a match in cycle n saw D=0 in cycle n+1.
- fail_seen  out  1  sticky OR of fail.
- match_count  out  CNT_W  number of cycles with ≥1 match, saturating.
- fail_count  out  CNT_W  number of fail pulses, saturating.
- first_fail_cycle  out  TIME_W  cycle index where D was missing for the first fail; valid when fail_seen=1.
- cycle  out  TIME_W  cycle index, saturating at all-ones.

Behaviour:
- Reset is synchronous active-low. When resetn=0 at a posedge, all registers and outputs clear to 0 and inputs in that cycle are ignored.
- Cycle n is the first cycle after reset release: cycle=0 in that cycle, incrementing by 1 per clock and saturating.
- Sequence semantics, decided: A at t0, B at t0+1..t0+k with k≥1, C at t0+k+1. A B and C in the same cycle at t0+1 (k=0) is NOT a match.
- Attempts start every cycle A=1 and overlap freely. Attempts in the same phase are merged, which is exact because all of them require the same D.
- Two phase registers:
  - s0: "A seen last cycle, need B now".
  - s1: "≥1 B seen, C may match now".
- Next-state equations:
  - s0' = A & ~abort.
  - FIRST_MATCH=1: s1' = ((s0 & B) | (s1 & B & ~C)) & ~abort.
  - FIRST_MATCH=0: s1' = ((s0 & B) | (s1 & B)) & ~abort.
- Hit term: hit = s1 & C & ~abort, computed combinationally in cycle n. match <= hit.
- When s0 and s1 are both set and B&C=1, the s1 attempts match and the s0 attempts advance to s1. These are distinct attempts; both effects apply.
- If B=0 and C=0 (or C=1 only via s0), the affected attempts die.
- D-check: chk <= hit. In the next cycle, fail <= chk & ~D & ~abort. An abort in the check cycle suppresses that fail.
- On a fail pulse:
  - fail_count increments, saturating at 2^CNT_W-1.
  - fail_seen <= 1.
  - If fail_seen was 0, first_fail_cycle <= cycle-1, the D cycle.
- match_count increments once per match pulse, no matter how many attempts merged; it saturates.
- A new match and a fail from an earlier match may both pulse in the same cycle; both are counted.
- abort does not clear fail_seen, the counters, first_fail_cycle or cycle.
- Reset mid-operation discards all attempts and any pending check.
- No combinational path from inputs to outputs; every output is registered.
- Latency is fixed: C→match is 1 cycle, C→fail is 2 cycles.

Test Plan:
- Scenario 1, FIRST_MATCH=1:
  - Stimulus: A@1, B@2..14, C@6,15, D@7.
  - Required: match in cycle 7 only; fail never; after cycle 31, match_count=1, fail_count=0.
- Scenario 2, FIRST_MATCH=0, same trace as scenario 1:
  - Required: match in cycles 7 and 16; fail in cycle 17; fail_count=1; first_fail_cycle=16; fail_seen=1.
- Scenario 3, FIRST_MATCH=1:
  - Stimulus: A@1,5, B@2..14, C@6,11,15, D@7.
  - Required: the A@5 attempt does not match at 6 (k=0); matches in cycles 7 and 12; fail in cycle 13; first_fail_cycle=12; match_count=2.
  - Adding D@12 gives fail_count=0.
- Scenario 4, FIRST_MATCH=1:
  - Stimulus: A@1,4, B@2..14, C@6,11,15, D@7.
  - Required: both attempts match at 6 and are merged into a single match in cycle 7; match_count=1; no fail.
- Scenario 5, abort, trace from scenario 3 with abort=1 in cycle 8 only:
  - Required: the A@5 attempt is dropped, so there is no match at 12 and no fail; match_count stays 1.
  - Repeat with resetn=0 in cycle 8: all outputs 0 in cycle 9 and cycle restarts at 0.
- Scenario 6, saturation, CNT_W=2, A=B=C=1 from cycle 0, D=0:
  - Required: first match in cycle 3; fail every cycle from 4; fail_count saturates at 3; first_fail_cycle=3; match_count saturates at 3.

Source files
------------

// File: rtl/firstmatch_monitor.sv
// Purpose : synthesizable checker for first_match(A ##1 B[*] ##1 C) |=> D with pulse, sticky and counted results.
// Latency : C -> match is 1 cycle, C -> fail is 2 cycles; every output is registered.
// Backpress: none; this is a passive observer that samples its inputs every cycle.
module firstmatch_monitor #(
  parameter int FIRST_MATCH = 1,
  parameter int CNT_W       = 8,
  parameter int TIME_W      = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              A,
  input  logic              B,
  input  logic              C,
  input  logic              D,
  input  logic              abort,
  output logic              match,
  output logic              fail,
  output logic              fail_seen,
  output logic [CNT_W-1:0]  match_count,
  output logic [CNT_W-1:0]  fail_count,
  output logic [TIME_W-1:0] first_fail_cycle,
  output logic [TIME_W-1:0] cycle
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [TIME_W-1:0] TIME_MAX = {TIME_W{1'b1}};
  localparam logic [TIME_W-1:0] TIME_ONE = TIME_W'(1);

  // Phase state. Every attempt in the same phase needs the same future D,
  // so one bit per phase is an exact summary of any number of attempts.
  logic              r_s0;   // A seen last cycle, B required now
  logic              r_s1;   // at least one B seen, C may match now
  logic              r_chk;  // a match happened last cycle, D is checked now

  logic              r_match;
  logic              r_fail;
  logic              r_fail_seen;
  logic [CNT_W-1:0]  r_match_count;
  logic [CNT_W-1:0]  r_fail_count;
  logic [TIME_W-1:0] r_first_fail_cycle;
  logic [TIME_W-1:0] r_cycle;

  logic              w_s1_stay;
  logic              w_s0_nxt;
  logic              w_s1_nxt;
  logic              w_hit;
  logic              w_fail_nxt;
  logic [TIME_W-1:0] w_cycle_nxt;
  logic [CNT_W-1:0]  w_match_count_nxt;
  logic [CNT_W-1:0]  w_fail_count_nxt;

  // With first-match semantics a C retires the s1 attempts; otherwise they
  // ride on through the B-run and may match again at a later C.
  assign w_s1_stay = (FIRST_MATCH != 0) ? ~C : 1'b1;

  // A fresh attempt enters s0 every cycle A is high. s0 attempts that see B
  // advance to s1 even when the s1 attempts are matching in the same cycle:
  // those are different attempts. A C seen straight from s0 (k=0) is not a
  // match, and s0/s1 attempts without a B simply die.
  assign w_s0_nxt = A & ~abort;
  assign w_s1_nxt = ((r_s0 & B) | (r_s1 & B & w_s1_stay)) & ~abort;
  assign w_hit    = r_s1 & C & ~abort;

  // The consequent is checked one cycle after the match; abort in the check
  // cycle cancels the pending check.
  assign w_fail_nxt = r_chk & ~D & ~abort;

  assign w_cycle_nxt       = (r_cycle == TIME_MAX) ? r_cycle : r_cycle + TIME_ONE;
  assign w_match_count_nxt = (r_match_count == CNT_MAX) ? r_match_count : r_match_count + CNT_ONE;
  assign w_fail_count_nxt  = (r_fail_count == CNT_MAX) ? r_fail_count : r_fail_count + CNT_ONE;

  // Advance the two sequence phase registers.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      r_s0 <= w_s0_nxt;
      r_s1 <= w_s1_nxt;
    end
  end

  // Register the match pulse, the pending D-check and the fail pulse.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_match <= 1'b0;
      r_chk   <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_match <= w_hit;
      r_chk   <= w_hit;
      r_fail  <= w_fail_nxt;
    end
  end

  // Sticky and counted results; abort deliberately leaves these alone.
  // They update on the same edge that raises the fail/match pulse, so the
  // counters already include a pulse in the cycle it is visible. At that
  // edge r_cycle still holds the D cycle, i.e. (fail cycle - 1).
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_fail_seen        <= 1'b0;
      r_match_count      <= '0;
      r_fail_count       <= '0;
      r_first_fail_cycle <= '0;
    end else begin
      if (w_hit) begin
        r_match_count <= w_match_count_nxt;
      end
      if (w_fail_nxt) begin
        r_fail_count <= w_fail_count_nxt;
        r_fail_seen  <= 1'b1;
        if (!r_fail_seen) begin
          r_first_fail_cycle <= r_cycle;
        end
      end
    end
  end

  // Saturating cycle index; reads 0 in the first cycle after reset release.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= w_cycle_nxt;
    end
  end

  assign match            = r_match;
  assign fail             = r_fail;
  assign fail_seen        = r_fail_seen;
  assign match_count      = r_match_count;
  assign fail_count       = r_fail_count;
  assign first_fail_cycle = r_first_fail_cycle;
  assign cycle            = r_cycle;

endmodule

// File: tb/tb_firstmatch_monitor.sv
// Bench for firstmatch_monitor: three instances (first-match, all-match,
// 2-bit counters) share one directed stimulus; a scoreboard holds the
// expected match/fail pulses and a negedge monitor consumes them.
module tb_firstmatch_monitor;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic resetn = 1'b0;
  logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0, abort = 1'b0;

  logic       o_match [3];
  logic       o_fail  [3];
  logic [4:0] o_cyc   [3];

  logic       fs1, fs0, fs2;
  logic [7:0] mc1, fc1, mc0, fc0;
  logic [1:0] mc2, fc2;
  logic [4:0] ffc1, ffc0, ffc2;

  firstmatch_monitor #(.FIRST_MATCH(1), .CNT_W(8), .TIME_W(5)) u_fm1 (
    .clock(clock), .resetn(resetn), .A(A), .B(B), .C(C), .D(D), .abort(abort),
    .match(o_match[0]), .fail(o_fail[0]), .fail_seen(fs1), .match_count(mc1),
    .fail_count(fc1), .first_fail_cycle(ffc1), .cycle(o_cyc[0]));

  firstmatch_monitor #(.FIRST_MATCH(0), .CNT_W(8), .TIME_W(5)) u_fm0 (
    .clock(clock), .resetn(resetn), .A(A), .B(B), .C(C), .D(D), .abort(abort),
    .match(o_match[1]), .fail(o_fail[1]), .fail_seen(fs0), .match_count(mc0),
    .fail_count(fc0), .first_fail_cycle(ffc0), .cycle(o_cyc[1]));

  firstmatch_monitor #(.FIRST_MATCH(1), .CNT_W(2), .TIME_W(5)) u_sat (
    .clock(clock), .resetn(resetn), .A(A), .B(B), .C(C), .D(D), .abort(abort),
    .match(o_match[2]), .fail(o_fail[2]), .fail_seen(fs2), .match_count(mc2),
    .fail_count(fc2), .first_fail_cycle(ffc2), .cycle(o_cyc[2]));

  typedef struct {
    int dut;
    int cyc;
    bit is_fail;
  } ev_t;

  ev_t  sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_n    = 0;
  int   exp_cyc  = 0;
  bit   run_en   = 1'b0;
  logic [2:0] mon_en = 3'b000;

  function automatic logic [39:0] bt(input int n);
    logic [39:0] m;
    m = '0;
    m[n] = 1'b1;
    return m;
  endfunction

  function automatic logic [39:0] rng(input int lo, input int hi);
    logic [39:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int dut, input int cyc, input bit is_fail);
    ev_t e;
    e.dut = dut;
    e.cyc = cyc;
    e.is_fail = is_fail;
    sb.push_back(e);
  endtask

  // Match an observed pulse against the scoreboard.
  task automatic consume(input int d, input bit f);
    int idx;
    idx = -1;
    n_checks++;
    for (int i = 0; i < sb.size(); i++)
      if (idx < 0 && sb[i].dut == d && sb[i].is_fail == f && sb[i].cyc == cur_n) idx = i;
    if (idx >= 0) sb.delete(idx);
    else begin
      n_fail++;
      $display("FAIL pulse dut%0d %s: seen in cycle %0d, expected no pulse", d, f ? "fail" : "match", cur_n);
    end
  endtask

  // Anything still queued is a pulse the DUT never produced.
  task automatic drain(input string scn);
    while (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s missing dut%0d %s: got no pulse, expected one in cycle %0d",
               scn, sb[0].dut, sb[0].is_fail ? "fail" : "match", sb[0].cyc);
      void'(sb.pop_front());
    end
  endtask

  // Monitor: cycle index every cycle, pulses whenever presented.
  always @(negedge clock) begin
    if (run_en) begin
      for (int d = 0; d < 3; d++) begin
        if (mon_en[d]) begin
          n_checks++;
          if (o_cyc[d] !== exp_cyc[4:0]) begin
            n_fail++;
            $display("FAIL cycle dut%0d at %0d: got %0d, expected %0d", d, cur_n, o_cyc[d], exp_cyc);
          end
          if (o_match[d] === 1'b1) consume(d, 1'b0);
          if (o_fail[d] === 1'b1) consume(d, 1'b1);
        end
      end
    end
  end

  task automatic run_scn(input logic [39:0] am, input logic [39:0] bm, input logic [39:0] cm,
                         input logic [39:0] dm, input logic [39:0] abm, input logic [39:0] rsm,
                         input int ncyc, input logic [2:0] en);
    run_en = 1'b0;
    mon_en = 3'b000;
    A = 1'b0; B = 1'b0; C = 1'b0; D = 1'b0; abort = 1'b0;
    resetn = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    resetn  = 1'b1;
    cur_n   = 0;
    exp_cyc = 0;
    mon_en  = en;
    run_en  = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      A = am[n]; B = bm[n]; C = cm[n]; D = dm[n]; abort = abm[n];
      resetn = ~rsm[n];
      @(posedge clock);
      #1;
      cur_n = n + 1;
      if (rsm[n]) begin
        exp_cyc = 0;
        chk("rst_match", int'(o_match[0]), 0);
        chk("rst_fail", int'(o_fail[0]), 0);
        chk("rst_fail_seen", int'(fs1), 0);
        chk("rst_match_count", int'(mc1), 0);
        chk("rst_fail_count", int'(fc1), 0);
        chk("rst_first_fail_cycle", int'(ffc1), 0);
      end else if (exp_cyc < 31) begin
        exp_cyc++;
      end
    end
    A = 1'b0; B = 1'b0; C = 1'b0; D = 1'b0; abort = 1'b0; resetn = 1'b1;
    @(negedge clock);
    #1;
    run_en = 1'b0;
  endtask

  logic [39:0] z;
  logic [39:0] c3;

  initial begin
    z  = '0;
    c3 = bt(6) | bt(11) | bt(15);

    // Scenarios 1 and 2: one trace, first-match and all-match instances.
    expect_ev(0, 7, 1'b0);
    expect_ev(1, 7, 1'b0);
    expect_ev(1, 16, 1'b0);
    expect_ev(1, 17, 1'b1);
    run_scn(bt(1), rng(2, 14), bt(6) | bt(15), bt(7), z, z, 32, 3'b011);
    drain("s1");
    chk("s1_match_count", int'(mc1), 1);
    chk("s1_fail_count", int'(fc1), 0);
    chk("s1_fail_seen", int'(fs1), 0);
    chk("s1_cycle_sat", int'(o_cyc[0]), 31);
    chk("s2_match_count", int'(mc0), 2);
    chk("s2_fail_count", int'(fc0), 1);
    chk("s2_fail_seen", int'(fs0), 1);
    chk("s2_first_fail_cycle", int'(ffc0), 16);

    // Scenario 3: k=0 attempt does not match, second attempt fails.
    expect_ev(0, 7, 1'b0);
    expect_ev(0, 12, 1'b0);
    expect_ev(0, 13, 1'b1);
    run_scn(bt(1) | bt(5), rng(2, 14), c3, bt(7), z, z, 20, 3'b001);
    drain("s3");
    chk("s3_match_count", int'(mc1), 2);
    chk("s3_fail_count", int'(fc1), 1);
    chk("s3_fail_seen", int'(fs1), 1);
    chk("s3_first_fail_cycle", int'(ffc1), 12);

    // Scenario 3b: D also present at 12.
    expect_ev(0, 7, 1'b0);
    expect_ev(0, 12, 1'b0);
    run_scn(bt(1) | bt(5), rng(2, 14), c3, bt(7) | bt(12), z, z, 20, 3'b001);
    drain("s3b");
    chk("s3b_match_count", int'(mc1), 2);
    chk("s3b_fail_count", int'(fc1), 0);

    // Scenario 4: two attempts merge into one match.
    expect_ev(0, 7, 1'b0);
    run_scn(bt(1) | bt(4), rng(2, 14), c3, bt(7), z, z, 20, 3'b001);
    drain("s4");
    chk("s4_match_count", int'(mc1), 1);
    chk("s4_fail_count", int'(fc1), 0);

    // Scenario 5: abort in cycle 8 drops the later attempt.
    expect_ev(0, 7, 1'b0);
    run_scn(bt(1) | bt(5), rng(2, 14), c3, bt(7), bt(8), z, 20, 3'b001);
    drain("s5");
    chk("s5_match_count", int'(mc1), 1);
    chk("s5_fail_count", int'(fc1), 0);
    chk("s5_fail_seen", int'(fs1), 0);

    // Scenario 5b: reset in cycle 8 clears everything.
    expect_ev(0, 7, 1'b0);
    run_scn(bt(1) | bt(5), rng(2, 14), c3, bt(7), z, bt(8), 20, 3'b001);
    drain("s5b");
    chk("s5b_match_count", int'(mc1), 0);
    chk("s5b_fail_count", int'(fc1), 0);
    chk("s5b_cycle", int'(o_cyc[0]), 11);

    // Scenario 6: continuous A=B=C=1, D=0 with 2-bit counters.
    for (int n = 3; n <= 12; n++) expect_ev(2, n, 1'b0);
    for (int n = 4; n <= 12; n++) expect_ev(2, n, 1'b1);
    run_scn(rng(0, 39), rng(0, 39), rng(0, 39), z, z, z, 12, 3'b100);
    drain("s6");
    chk("s6_match_count", int'(mc2), 3);
    chk("s6_fail_count", int'(fc2), 3);
    chk("s6_fail_seen", int'(fs2), 1);
    chk("s6_first_fail_cycle", int'(ffc2), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
